shared_buf_arbiter: RTL and testbench

//  Generalised N-way arbiter for a shared resource (app_data, UDP RX/TX buffers, payload memory) between the ROS2 core, CPU and future agents.

---
 rtl/shared_buf_arbiter.sv | 125 ++++++++++++
 tb/tb_shared_buf_arbiter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/shared_buf_arbiter.sv
// N-way request/release arbiter for a shared buffer: round-robin or fixed priority, reset-time parking owner.
// Optional hold watchdog when ARB_TIMEOUT_EN is defined (revokes a grant held HOLD_TIMEOUT cycles).
module shared_buf_arbiter #(
  parameter  int NUM_REQ      = 4,
  parameter  int PRIO_MODE    = 0,
  parameter  int RESET_OWNER  = 4,
  parameter  int HOLD_TIMEOUT = 0,
  localparam int OW           = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] rel,
  output logic [NUM_REQ-1:0] grant,
  output logic [OW-1:0]      owner_id,
  output logic               busy,
  output logic [NUM_REQ-1:0] revoked
);

  typedef enum logic {IDLE, OWNED} state_t;

  localparam bit            RST_OWNED = (RESET_OWNER < NUM_REQ);
  localparam logic [OW-1:0] RST_ID    = RST_OWNED ? OW'(RESET_OWNER) : '0;

  state_t               state_q, state_d;
  logic [OW-1:0]        owner_q, owner_d;
  logic [OW-1:0]        rr_q, rr_d;
  logic [NUM_REQ-1:0]   revoked_q, revoked_d;
  logic                 win_found;
  logic [OW-1:0]        win_id;
  logic                 rel_own;
  logic                 wd_fire;

  // Search order position -> requester index, rotated by base and wrapped at NUM_REQ.
  function automatic logic [OW-1:0] idx_at(input int base, input int off);
    int s;
    s = base + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return OW'(s);
  endfunction

  // Walk the search order backwards so the earliest hit is the last one written.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (req[idx_at((PRIO_MODE != 0) ? 0 : int'(rr_q), i)]) begin
        win_found = 1'b1;
        win_id    = idx_at((PRIO_MODE != 0) ? 0 : int'(rr_q), i);
      end
    end
  end

  assign rel_own = rel[owner_q];

`ifdef ARB_TIMEOUT_EN
  localparam int CW = (HOLD_TIMEOUT > 0) ? $clog2(HOLD_TIMEOUT + 1) : 1;
  logic [CW-1:0] hold_q;

  // Held at zero while IDLE, so every entry into OWNED starts counting from 0.
  always_ff @(posedge clk) begin
    if (rst || state_q == IDLE) hold_q <= '0;
    else                        hold_q <= hold_q + 1'b1;
  end

  assign wd_fire = (HOLD_TIMEOUT != 0) && (hold_q == CW'(HOLD_TIMEOUT - 1));
`else
  assign wd_fire = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_d      = rr_q;
    revoked_d = '0;
    case (state_q)
      IDLE: begin
        if (enable && win_found) begin
          state_d = OWNED;
          owner_d = win_id;
          rr_d    = (win_id == OW'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
        end
      end
      OWNED: begin
        // A release in the watchdog's last cycle is a normal release: no revoke pulse.
        if (rel_own) begin
          state_d = IDLE;
          owner_d = '0;
        end else if (wd_fire) begin
          state_d            = IDLE;
          owner_d            = '0;
          revoked_d[owner_q] = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RST_OWNED ? OWNED : IDLE;
      owner_q   <= RST_ID;
      rr_q      <= '0;
      revoked_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      revoked_q <= revoked_d;
    end
  end

  assign busy     = (state_q == OWNED);
  assign owner_id = owner_q;
  assign revoked  = revoked_q;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign grant[g] = enable & busy & (owner_q == OW'(g));
  end

endmodule

// File: tb/tb_shared_buf_arbiter.sv
// Directed bench for shared_buf_arbiter: round-robin, fixed-priority, 2-way parked and watchdog instances.
module tb_shared_buf_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // A: round-robin, no reset owner
  logic en_a = 1'b1; logic [3:0] req_a = '0, rel_a = '0, grant_a, rev_a; logic [1:0] id_a; logic busy_a;
  // B: fixed priority
  logic en_b = 1'b1; logic [3:0] req_b = '0, rel_b = '0, grant_b, rev_b; logic [1:0] id_b; logic busy_b;
  // C: two requesters, parked on 1
  logic en_c = 1'b1; logic [1:0] req_c = '0, rel_c = '0, grant_c, rev_c; logic id_c; logic busy_c;
  // D: round-robin with HOLD_TIMEOUT=8
  logic en_d = 1'b1; logic [3:0] req_d = '0, rel_d = '0, grant_d, rev_d; logic [1:0] id_d; logic busy_d;

  shared_buf_arbiter #(.NUM_REQ(4), .PRIO_MODE(0), .RESET_OWNER(4), .HOLD_TIMEOUT(0)) u_a (
    .clk(clk), .rst(rst), .enable(en_a), .req(req_a), .rel(rel_a),
    .grant(grant_a), .owner_id(id_a), .busy(busy_a), .revoked(rev_a));
  shared_buf_arbiter #(.NUM_REQ(4), .PRIO_MODE(1), .RESET_OWNER(4), .HOLD_TIMEOUT(0)) u_b (
    .clk(clk), .rst(rst), .enable(en_b), .req(req_b), .rel(rel_b),
    .grant(grant_b), .owner_id(id_b), .busy(busy_b), .revoked(rev_b));
  shared_buf_arbiter #(.NUM_REQ(2), .PRIO_MODE(0), .RESET_OWNER(1), .HOLD_TIMEOUT(0)) u_c (
    .clk(clk), .rst(rst), .enable(en_c), .req(req_c), .rel(rel_c),
    .grant(grant_c), .owner_id(id_c), .busy(busy_c), .revoked(rev_c));
  shared_buf_arbiter #(.NUM_REQ(4), .PRIO_MODE(0), .RESET_OWNER(4), .HOLD_TIMEOUT(8)) u_d (
    .clk(clk), .rst(rst), .enable(en_d), .req(req_d), .rel(rel_d),
    .grant(grant_d), .owner_id(id_d), .busy(busy_d), .revoked(rev_d));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (grant_a !== 4'b0000) begin errors++; $display("FAIL rst_a_grant act=%b exp=%b", grant_a, 4'b0000); end
    checks++; if (id_a !== 2'd0 || busy_a !== 1'b0) begin errors++; $display("FAIL rst_a_idle id=%0d busy=%b exp id=0 busy=0", id_a, busy_a); end
    checks++; if (rev_a !== 4'b0000) begin errors++; $display("FAIL rst_a_rev act=%b exp=%b", rev_a, 4'b0000); end
    checks++; if (grant_c !== 2'b10 || id_c !== 1'b1 || busy_c !== 1'b1) begin errors++; $display("FAIL rst_c_park grant=%b id=%0d busy=%b exp 10/1/1", grant_c, id_c, busy_c); end
    checks++; if (busy_b !== 1'b0 || busy_d !== 1'b0) begin errors++; $display("FAIL rst_bd_idle busy_b=%b busy_d=%b exp 0/0", busy_b, busy_d); end
    rst = 1'b0;
  endtask

  task automatic test_round_robin();
    req_a = 4'b0110; tick();
    checks++; if (grant_a !== 4'b0010 || id_a !== 2'd1 || busy_a !== 1'b1) begin errors++; $display("FAIL rr_first grant=%b id=%0d busy=%b exp 0010/1/1", grant_a, id_a, busy_a); end
    tick(); tick();
    checks++; if (grant_a !== 4'b0010) begin errors++; $display("FAIL rr_hold act=%b exp=%b", grant_a, 4'b0010); end
    rel_a = 4'b0010; tick(); rel_a = '0;
    checks++; if (grant_a !== 4'b0000 || busy_a !== 1'b0 || id_a !== 2'd0) begin errors++; $display("FAIL rr_gap grant=%b busy=%b id=%0d exp 0000/0/0", grant_a, busy_a, id_a); end
    tick();
    checks++; if (grant_a !== 4'b0100 || id_a !== 2'd2) begin errors++; $display("FAIL rr_second grant=%b id=%0d exp 0100/2", grant_a, id_a); end
    req_a = 4'b1111; rel_a = 4'b0100; tick(); rel_a = '0;
    checks++; if (grant_a !== 4'b0000) begin errors++; $display("FAIL rr_gap2 act=%b exp=%b", grant_a, 4'b0000); end
    tick();
    checks++; if (grant_a !== 4'b1000 || id_a !== 2'd3) begin errors++; $display("FAIL rr_third grant=%b id=%0d exp 1000/3", grant_a, id_a); end
    rel_a = 4'b1000; tick(); rel_a = '0;
    tick();
    checks++; if (grant_a !== 4'b0001 || id_a !== 2'd0) begin errors++; $display("FAIL rr_wrap grant=%b id=%0d exp 0001/0", grant_a, id_a); end
    req_a = '0; rel_a = 4'b0001; tick(); rel_a = '0;
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rr_release busy act=%b exp=0", busy_a); end
  endtask

  task automatic test_enable();
    req_a = 4'b0100; tick(); req_a = '0;
    checks++; if (grant_a !== 4'b0100) begin errors++; $display("FAIL en_acquire act=%b exp=%b", grant_a, 4'b0100); end
    en_a = 1'b0; #1;
    checks++; if (grant_a !== 4'b0000) begin errors++; $display("FAIL en_gate_same_cycle act=%b exp=%b", grant_a, 4'b0000); end
    tick();
    checks++; if (grant_a !== 4'b0000 || busy_a !== 1'b1 || id_a !== 2'd2) begin errors++; $display("FAIL en_kept grant=%b busy=%b id=%0d exp 0000/1/2", grant_a, busy_a, id_a); end
    en_a = 1'b1; #1;
    checks++; if (grant_a !== 4'b0100) begin errors++; $display("FAIL en_restore act=%b exp=%b", grant_a, 4'b0100); end
    en_a = 1'b0; rel_a = 4'b0100; tick(); rel_a = '0;
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL en_rel_honoured busy act=%b exp=0", busy_a); end
    req_a = 4'b0001; tick(); tick();
    checks++; if (busy_a !== 1'b0 || grant_a !== 4'b0000) begin errors++; $display("FAIL en_inhibit busy=%b grant=%b exp 0/0000", busy_a, grant_a); end
    en_a = 1'b1; tick();
    checks++; if (grant_a !== 4'b0001 || id_a !== 2'd0) begin errors++; $display("FAIL en_resume grant=%b id=%0d exp 0001/0", grant_a, id_a); end
    rel_a = 4'b0001; tick(); rel_a = '0;
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL relreq_release_wins busy act=%b exp=0", busy_a); end
    tick();
    checks++; if (grant_a !== 4'b0001) begin errors++; $display("FAIL relreq_rearb act=%b exp=%b", grant_a, 4'b0001); end
    req_a = '0; rel_a = 4'b0001; tick(); rel_a = '0;
  endtask

  task automatic test_fixed_prio();
    req_b = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (grant_b !== 4'b0001) begin errors++; $display("FAIL prio_lowest[%0d] act=%b exp=%b", i, grant_b, 4'b0001); end
      rel_b = 4'b0001; tick(); rel_b = '0;
      checks++; if (grant_b !== 4'b0000) begin errors++; $display("FAIL prio_gap[%0d] act=%b exp=%b", i, grant_b, 4'b0000); end
    end
    req_b = 4'b1110; tick();
    checks++; if (grant_b !== 4'b0010 || id_b !== 2'd1) begin errors++; $display("FAIL prio_next grant=%b id=%0d exp 0010/1", grant_b, id_b); end
    req_b = '0; rel_b = 4'b0010; tick(); rel_b = '0;
  endtask

  task automatic test_park_two();
    rel_c = 2'b01; tick(); rel_c = '0;
    checks++; if (grant_c !== 2'b10 || busy_c !== 1'b1) begin errors++; $display("FAIL park_nonowner_rel grant=%b busy=%b exp 10/1", grant_c, busy_c); end
    rel_c = 2'b10; tick(); rel_c = '0;
    checks++; if (grant_c !== 2'b00 || busy_c !== 1'b0 || id_c !== 1'b0) begin errors++; $display("FAIL park_release grant=%b busy=%b id=%0d exp 00/0/0", grant_c, busy_c, id_c); end
    rel_c = 2'b10; tick(); rel_c = '0;
    checks++; if (busy_c !== 1'b0) begin errors++; $display("FAIL park_idle_rel busy act=%b exp=0", busy_c); end
  endtask

  task automatic test_watchdog();
    req_d = 4'b0001; tick(); req_d = '0;
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++; if (grant_d !== 4'b0001 || rev_d !== 4'b0000) begin errors++; $display("FAIL wd_held[%0d] grant=%b rev=%b exp 0001/0000", i, grant_d, rev_d); end
    end
    tick();
    checks++; if (grant_d !== 4'b0000 || rev_d !== 4'b0001) begin errors++; $display("FAIL wd_revoke grant=%b rev=%b exp 0000/0001", grant_d, rev_d); end
    tick();
    checks++; if (rev_d !== 4'b0000) begin errors++; $display("FAIL wd_pulse_len act=%b exp=%b", rev_d, 4'b0000); end
    req_d = 4'b0001; tick(); req_d = '0;
    repeat (7) tick();
    rel_d = 4'b0001; tick(); rel_d = '0;
    checks++; if (grant_d !== 4'b0000 || rev_d !== 4'b0000) begin errors++; $display("FAIL wd_rel_last grant=%b rev=%b exp 0000/0000", grant_d, rev_d); end
`else
    repeat (12) tick();
    checks++; if (grant_d !== 4'b0001 || rev_d !== 4'b0000) begin errors++; $display("FAIL hold_no_wd grant=%b rev=%b exp 0001/0000", grant_d, rev_d); end
    rel_d = 4'b0001; tick(); rel_d = '0;
    checks++; if (busy_d !== 1'b0) begin errors++; $display("FAIL hold_release busy act=%b exp=0", busy_d); end
`endif
  endtask

  task automatic test_reset_mid();
    req_a = 4'b0010; tick();
    checks++; if (grant_a !== 4'b0010) begin errors++; $display("FAIL mid_acquire act=%b exp=%b", grant_a, 4'b0010); end
    rst = 1'b1; tick();
    checks++; if (grant_a !== 4'b0000 || busy_a !== 1'b0 || rev_a !== 4'b0000) begin errors++; $display("FAIL mid_reset grant=%b busy=%b rev=%b exp 0000/0/0000", grant_a, busy_a, rev_a); end
    checks++; if (grant_c !== 2'b10) begin errors++; $display("FAIL mid_reset_park act=%b exp=%b", grant_c, 2'b10); end
    rst = 1'b0; tick();
    checks++; if (grant_a !== 4'b0010 || id_a !== 2'd1) begin errors++; $display("FAIL mid_regrant grant=%b id=%0d exp 0010/1", grant_a, id_a); end
    req_a = '0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_enable();
    test_fixed_prio();
    test_park_two();
    test_watchdog();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
